// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-port data memory between the fetch stage
//             (read-only) and the memory stage (read/write). Each access is
//             sequenced through issue, latency wait and completion. Addresses
//             beyond the last legal word complete with an error flag and never
//             reach the array.
//  Ports    : clk, rst_n              clock, synchronous active-low reset
//             f_req/f_addr            fetch request and byte address
//             f_gnt/f_done            fetch accept (comb) / completion pulse
//             f_rdata/f_err           fetch read data / range error
//             m_req/m_we/m_addr       memory-stage request, direction, address
//             m_wdata                 memory-stage write data
//             m_gnt/m_done            memory-stage accept (comb) / completion
//             m_rdata/dmem_error      memory-stage read data / range error
//             mem_en/mem_we           array strobe / write enable
//             mem_addr/mem_wdata      array address / write data
//             mem_rdata               array read data, MEM_LAT after mem_en
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WID = 64,
    parameter int ADDR_WID = 64,
    parameter int MEM_SIZE = 1024,
    parameter int MEM_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                f_req,
    input  logic [ADDR_WID-1:0] f_addr,
    output logic                f_gnt,
    output logic                f_done,
    output logic [DATA_WID-1:0] f_rdata,
    output logic                f_err,
    input  logic                m_req,
    input  logic                m_we,
    input  logic [ADDR_WID-1:0] m_addr,
    input  logic [DATA_WID-1:0] m_wdata,
    output logic                m_gnt,
    output logic                m_done,
    output logic [DATA_WID-1:0] m_rdata,
    output logic                dmem_error,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0] mem_wdata,
    input  logic [DATA_WID-1:0] mem_rdata
);

    localparam int                   c_cnt_w    = $clog2(MEM_LAT + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_load = c_cnt_w'(MEM_LAT - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [ADDR_WID-1:0]  c_max_addr = ADDR_WID'(MEM_SIZE - 8);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;

    // 1 = memory stage won the most recent conflict
    logic                r_last_win_m;

    // Latched access
    logic                r_own_m;
    logic                r_we;
    logic [ADDR_WID-1:0] r_addr;
    logic [DATA_WID-1:0] r_wdata;
    logic                r_err;
    logic [c_cnt_w-1:0]  r_cnt;

    // Registered outputs
    logic                r_f_done;
    logic                r_m_done;
    logic [DATA_WID-1:0] r_f_rdata;
    logic [DATA_WID-1:0] r_m_rdata;
    logic                r_f_err;
    logic                r_m_err;

    logic                w_f_gnt;
    logic                w_m_gnt;
    logic                w_mem_en;
    logic                w_finish;
    logic [ADDR_WID-1:0] w_sel_addr;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, grants and strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_f_gnt      = 1'b0;
        w_m_gnt      = 1'b0;
        w_mem_en     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (f_req && m_req) begin
                    // Conflict goes to whoever lost the previous one
                    w_f_gnt = r_last_win_m;
                    w_m_gnt = !r_last_win_m;
                end else begin
                    w_f_gnt = f_req;
                    w_m_gnt = m_req;
                end
                if (w_f_gnt || w_m_gnt) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue: begin
                if (r_err) begin
                    w_finish     = 1'b1;
                    w_next_state = c_st_done;
                end else begin
                    w_mem_en     = 1'b1;
                    w_next_state = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt == '0) begin
                    w_finish     = 1'b1;
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
        w_sel_addr = w_m_gnt ? m_addr : f_addr;
    end

    // ------------------------------------------------------------------------
    // Access latch, wait counter and completion registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_win_m <= 1'b0;
            r_own_m      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_f_done     <= 1'b0;
            r_m_done     <= 1'b0;
            r_f_rdata    <= '0;
            r_m_rdata    <= '0;
            r_f_err      <= 1'b0;
            r_m_err      <= 1'b0;
        end else begin
            r_f_done <= 1'b0;
            r_m_done <= 1'b0;

            if (w_f_gnt || w_m_gnt) begin
                r_own_m <= w_m_gnt;
                r_we    <= w_m_gnt && m_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_m_gnt ? m_wdata : '0;
                r_err   <= (w_sel_addr > c_max_addr);
                if (f_req && m_req) begin
                    r_last_win_m <= w_m_gnt;
                end
            end

            if (r_state == c_st_issue) begin
                r_cnt <= c_cnt_load;
            end else if (r_state == c_st_wait && r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_one;
            end

            // Done pulse and result registers update on the same edge, so the
            // data is valid exactly in the done cycle and held afterwards.
            if (w_finish) begin
                if (r_own_m) begin
                    r_m_done <= 1'b1;
                    r_m_err  <= r_err;
                    if (!r_we && !r_err) begin
                        r_m_rdata <= mem_rdata;
                    end
                end else begin
                    r_f_done <= 1'b1;
                    r_f_err  <= r_err;
                    if (!r_err) begin
                        r_f_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign f_gnt      = w_f_gnt;
    assign m_gnt      = w_m_gnt;
    assign f_done     = r_f_done;
    assign m_done     = r_m_done;
    assign f_rdata    = r_f_rdata;
    assign m_rdata    = r_m_rdata;
    assign f_err      = r_f_err;
    assign dmem_error = r_m_err;
    assign mem_en     = w_mem_en;
    assign mem_we     = w_mem_en && r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A memory responder answers
//             the array port; a transaction-level model predicts grants,
//             completion cycles, read data and error flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DATA_WID = 64;
    localparam int ADDR_WID = 64;
    localparam int MEM_SIZE = 1024;
    localparam int MEM_LAT  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        f_req,  m_req,  m_we;
    logic [63:0] f_addr, m_addr, m_wdata;
    logic        f_gnt, f_done, f_err, m_gnt, m_done, dmem_error, mem_en, mem_we;
    logic [63:0] f_rdata, m_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.DATA_WID(DATA_WID), .ADDR_WID(ADDR_WID),
                  .MEM_SIZE(MEM_SIZE), .MEM_LAT(MEM_LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
        .f_rdata(f_rdata), .f_err(f_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata), .dmem_error(dmem_error),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Second instance with single-cycle memory latency
    logic        f_req1,  m_req1,  m_we1;
    logic [63:0] f_addr1, m_addr1, m_wdata1;
    logic        f_gnt1, f_done1, f_err1, m_gnt1, m_done1, dmem_error1, mem_en1, mem_we1;
    logic [63:0] f_rdata1, m_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    mem_arbiter #(.DATA_WID(DATA_WID), .ADDR_WID(ADDR_WID),
                  .MEM_SIZE(MEM_SIZE), .MEM_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req1), .f_addr(f_addr1), .f_gnt(f_gnt1), .f_done(f_done1),
        .f_rdata(f_rdata1), .f_err(f_err1),
        .m_req(m_req1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_gnt(m_gnt1), .m_done(m_done1), .m_rdata(m_rdata1), .dmem_error(dmem_error1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    // ------------------------------------------------------------------------
    // Memory responder: 128 words, unwritten words hold a fixed pattern
    // ------------------------------------------------------------------------
    function automatic logic [63:0] init_word(input int idx);
        return ((64'(idx) ^ 64'd2) * 64'h9E3779B97F4A7C15) + 64'h1122334455667788;
    endfunction

    logic [63:0] mem_wr [0:127];
    logic        mem_wv [0:127];
    logic [63:0] rd_pipe [0:MEM_LAT-1];
    logic [63:0] rd1;
    logic        mem_clr;

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        int idx;
        idx = int'(a[9:3]);
        return mem_wv[idx] ? mem_wr[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 128; i++) mem_wv[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            mem_wr[mem_addr[9:3]] <= mem_wdata;
            mem_wv[mem_addr[9:3]] <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_read(mem_addr) : {$urandom, $urandom};
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        rd1 <= mem_en1 ? init_word(int'(mem_addr1[9:3])) : {$urandom, $urandom};
    end

    assign mem_rdata  = rd_pipe[MEM_LAT-1];
    assign mem_rdata1 = rd1;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------------
    logic [63:0] ref_wr [0:127];
    bit          ref_wv [0:127];
    bit          last_win_m;
    logic [63:0] e_f_rdata, e_m_rdata;
    logic        e_f_err,   e_m_err;
    bit          f_pend, m_pend, mw_p;
    logic [63:0] fa_p, ma_p, md_p;

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        int idx;
        idx = int'(a[9:3]);
        return ref_wv[idx] ? ref_wr[idx] : init_word(idx);
    endfunction

    task automatic new_req(input bit port_m, input logic [63:0] a, input bit we,
                           input logic [63:0] d);
        if (port_m) begin
            m_pend = 1; ma_p = a; mw_p = we; md_p = d;
            m_req = 1'b1; m_addr = a; m_we = we; m_wdata = d;
        end else begin
            f_pend = 1; fa_p = a;
            f_req = 1'b1; f_addr = a;
        end
    endtask

    // Called #1 after the edge opening an idle cycle, with requests driven.
    task automatic run_access();
        bit          win_m, err, we;
        logic [63:0] a, d;
        int          lat;
        #1;
        if (f_pend && m_pend) begin
            win_m      = !last_win_m;
            last_win_m = win_m;
        end else begin
            win_m = m_pend;
        end
        check_val("f_gnt", f_gnt, !win_m);
        check_val("m_gnt", m_gnt, win_m);
        a   = win_m ? ma_p : fa_p;
        we  = win_m && mw_p;
        d   = md_p;
        err = (a > 64'(MEM_SIZE - 8));
        lat = err ? 2 : MEM_LAT + 2;
        if (win_m) m_pend = 0; else f_pend = 0;
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            if (win_m) m_req = 1'b0; else f_req = 1'b0;
            #1;
            check_val("gnt_busy", {f_gnt, m_gnt}, 64'd0);
            check_val("mem_en", mem_en, (c == 1 && !err));
            if (c == 1 && !err) begin
                check_val("mem_we", mem_we, we);
                check_val("mem_addr", mem_addr, a);
                if (we) check_val("mem_wdata", mem_wdata, d);
            end
            if (c == lat) begin
                if (win_m) begin
                    e_m_err = err;
                    if (!err && we) begin
                        ref_wr[int'(a[9:3])] = d;
                        ref_wv[int'(a[9:3])] = 1;
                    end else if (!err) begin
                        e_m_rdata = ref_read(a);
                    end
                end else begin
                    e_f_err = err;
                    if (!err) e_f_rdata = ref_read(a);
                end
            end
            check_val("f_done", f_done, (c == lat && !win_m));
            check_val("m_done", m_done, (c == lat && win_m));
            check_val("f_rdata", f_rdata, e_f_rdata);
            check_val("m_rdata", m_rdata, e_m_rdata);
            check_val("f_err", f_err, e_f_err);
            check_val("dmem_error", dmem_error, e_m_err);
        end
    endtask

    task automatic next_idle();
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] r;
        if ($urandom_range(7) == 0) begin
            if ($urandom_range(1) == 0) r = 64'(MEM_SIZE - 7 + $urandom_range(63));
            else                        r = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        end else begin
            r = 64'($urandom_range(127)) << 3;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; mem_clr = 1'b1;
        f_req = 0; f_addr = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
        f_req1 = 0; f_addr1 = 0; m_req1 = 0; m_we1 = 0; m_addr1 = 0; m_wdata1 = 0;
        for (int i = 0; i < 128; i++) begin ref_wr[i] = '0; ref_wv[i] = 0; end
        last_win_m = 0; f_pend = 0; m_pend = 0; mw_p = 0;
        fa_p = 0; ma_p = 0; md_p = 0;
        e_f_rdata = 0; e_m_rdata = 0; e_f_err = 0; e_m_err = 0;

        repeat (3) @(posedge clk);
        #1; mem_clr = 1'b0;
        #1;
        check_val("rst_f_done", f_done, 0);
        check_val("rst_m_done", m_done, 0);
        check_val("rst_f_rdata", f_rdata, 0);
        check_val("rst_m_rdata", m_rdata, 0);
        check_val("rst_errs", {f_err, dmem_error}, 0);
        check_val("rst_mem_en", mem_en, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Fetch read of the known word at 0x10
        next_idle();
        new_req(0, 64'h10, 0, 0);
        run_access();
        check_val("tp_fetch_data", f_rdata, 64'h1122334455667788);

        // Memory-stage write
        next_idle();
        new_req(1, 64'h20, 1, 64'hDEADBEEF);
        run_access();

        // Continuous conflict: alternation m, f, m, f ...
        next_idle();
        new_req(0, 64'h28, 0, 0);
        new_req(1, 64'h20, 0, 0);
        run_access();
        for (int k = 0; k < 5; k++) begin
            next_idle();
            if (!f_pend) new_req(0, 64'h30 + 64'(k * 8), 0, 0);
            if (!m_pend) new_req(1, 64'h60 + 64'(k * 8), 1, {$urandom, $urandom});
            run_access();
        end
        next_idle();
        run_access();   // drain the remaining pending request

        // Range boundary
        next_idle();
        new_req(1, 64'd1017, 0, 0);
        run_access();
        next_idle();
        new_req(1, 64'd1016, 0, 0);
        run_access();

        // Reset in the WAIT cycle of a fetch read
        next_idle();
        new_req(0, 64'h40, 0, 0);
        #1; check_val("rst_gnt", f_gnt, 1);
        @(posedge clk); #1; f_req = 0; f_pend = 0;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        #1;
        e_f_rdata = 0; e_m_rdata = 0; e_f_err = 0; e_m_err = 0; last_win_m = 0;
        check_val("abort_f_done", f_done, 0);
        check_val("abort_f_rdata", f_rdata, 0);
        check_val("abort_m_rdata", m_rdata, 0);
        check_val("abort_mem_en", mem_en, 0);
        next_idle();
        new_req(1, 64'h18, 0, 0);
        run_access();
        // last_win must be back at fetch: first conflict goes to memory stage
        next_idle();
        new_req(0, 64'h48, 0, 0);
        new_req(1, 64'h50, 0, 0);
        run_access();
        check_val("post_rst_conflict", {f_pend, m_pend}, 64'b10);

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            next_idle();
            if (!f_pend && $urandom_range(1) == 1) new_req(0, rand_addr(), 0, 0);
            if (!m_pend && $urandom_range(1) == 1)
                new_req(1, rand_addr(), 1'($urandom_range(1)), {$urandom, $urandom});
            if (!f_pend && !m_pend) new_req(1, rand_addr(), 0, 0);
            run_access();
        end
        if (f_pend || m_pend) begin
            next_idle();
            run_access();
        end

        // Single-cycle latency instance
        next_idle();
        f_req1 = 1'b1; f_addr1 = 64'h10;
        #1; check_val("l1_gnt", f_gnt1, 1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1; f_req1 = 1'b0;
            #1;
            check_val("l1_mem_en", mem_en1, (c == 1));
            check_val("l1_f_done", f_done1, (c == 3));
            if (c == 3) begin
                check_val("l1_f_rdata", f_rdata1, 64'h1122334455667788);
                check_val("l1_f_err", f_err1, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle arbiter that shares the single-port data memory between the fetch stage (read-only) and the memory stage (read/write). It sits between the stage-side address/data logic and the memory array, and sequences each access through issue, latency wait and completion. It also flags out-of-range addresses as `dmem_error` without touching the array. Each requester sees a request/grant/done handshake.

## Interface

Parameters:
- `DATA_WID`, 64: data word width.
- `ADDR_WID`, 64: byte address width.
- `MEM_SIZE`, 1024: memory size in bytes; legal word addresses are 0 .. `MEM_SIZE`-8.
- `MEM_LAT`, 2: memory read latency in cycles (≥1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `f_req`  in  1  fetch read request (level).
- `f_addr`  in  `ADDR_WID`  fetch byte address.
- `f_gnt`  out  1  fetch request accepted this cycle (combinational).
- `f_done`  out  1  one-cycle completion pulse for fetch.
- `f_rdata`  out  `DATA_WID`  fetch read data, valid with `f_done`.
- `f_err`  out  1  out-of-range fetch, valid with `f_done`.
- `m_req`  in  1  memory-stage request (level).
- `m_we`  in  1  1 = write, 0 = read.
- `m_addr`  in  `ADDR_WID`  memory-stage byte address.
- `m_wdata`  in  `DATA_WID`  write data.
- `m_gnt`  out  1  memory-stage request accepted this cycle (combinational).
- `m_done`  out  1  one-cycle completion pulse for memory stage.
- `m_rdata`  out  `DATA_WID`  read data, valid with `m_done`.
- `dmem_error`  out  1  out-of-range memory-stage access, valid with `m_done`.
- `mem_en`  out  1  memory access strobe, exactly one cycle per access.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  `ADDR_WID`  memory address.
- `mem_wdata`  out  `DATA_WID`  memory write data.
- `mem_rdata`  in  `DATA_WID`  memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE: a request is accepted only here.
  - Only one of `f_req`/`m_req` high: that port's gnt = 1.
  - Both high (conflict): grant the port that lost the previous conflict. Register `last_win` resets to fetch, so the first conflict goes to the memory stage.
  - On acceptance, latch port id, we (0 for fetch), addr and wdata. Compute the range error: addr > `MEM_SIZE`-8. Go to ISSUE.
- ISSUE:
  - No error: `mem_en`=1 with latched we/addr/wdata. Load the wait counter with `MEM_LAT`-1 and go to WAIT.
  - Error: `mem_en` stays 0 and the FSM goes directly to DONE.
- WAIT: decrement the counter each cycle. When the counter reaches 0, capture `mem_rdata` (reads only) and go to DONE.
- DONE: the owning port's done = 1 for one cycle, together with its rdata and err. Go to IDLE.
- A write completes with the same timing as a read. Its rdata register is left unchanged.
- Requesters hold req, addr, we and wdata stable until gnt. A req still high after gnt is treated as a new request.
- gnt outputs are 0 in every state except IDLE.
- `f_rdata`, `m_rdata`, `f_err` and `dmem_error` are registers. They hold their values until the next done on their own port.
- The counter is `$clog2(MEM_LAT+1)` bits wide. Address comparison is unsigned and full-width.

## Timing

- Request accepted in cycle t.
  - Normal access: `mem_en` in cycle t+1; done in cycle t+`MEM_LAT`+2 (t+4 at default).
  - Error access: done in cycle t+2, with no `mem_en`.
- Back-to-back: the earliest next grant is in the cycle after DONE. Throughput is one access per `MEM_LAT`+3 cycles.
- Reset (`rst_n`=0 at an edge), including mid-access:
  - FSM goes to IDLE and `last_win` to fetch.
  - All outputs go to 0: done, err and mem_* signals, and rdata registers = 0.
  - No done is issued for the aborted access. A write already strobed is not undone.

## Test plan

- Fetch read, addr 0x10, `mem_rdata`=0x1122334455667788 -> `f_gnt` at t, `mem_en`=1/`mem_we`=0/`mem_addr`=0x10 at t+1, `f_done`=1 with `f_rdata`=0x1122334455667788 at t+4, `f_err`=0.
- Memory-stage write, addr 0x20, data 0xDEADBEEF -> `mem_en`=1, `mem_we`=1, `mem_wdata`=0xDEADBEEF at t+1; `m_done` at t+4; `dmem_error`=0; `m_rdata` unchanged.
- `f_req` and `m_req` both held high continuously -> grants alternate m, f, m, f with 5 cycles between grants; each port receives done only for its own access.
- Memory-stage read at addr `MEM_SIZE`-7 (1017) -> no `mem_en`, `m_done`=1 with `dmem_error`=1 at t+2; next access at addr 1016 completes with `dmem_error`=0.
- Assert `rst_n`=0 in the WAIT cycle of a fetch read -> next cycle: FSM in IDLE, `f_done`=0, `f_rdata`=0, `mem_en`=0; after release, a fresh `m_req` is granted immediately.
- `MEM_LAT`=1 build, fetch read -> `f_done` at t+3 with the data presented in cycle t+2.
